// File: rtl/dfi_init_ctrl.sv
// DRAM power-up sequencer: DFI reset/CKE sequencing followed by a PHY training request.
// Define DFI_INIT_TIMEOUT_EN to add the training timeout and the FAIL state.
module dfi_init_ctrl #(
    parameter int unsigned RESET_CYCLES   = 200,
    parameter int unsigned CKE_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic start,
    input  logic dfi_init_complete,
    output logic dfi_reset_n,
    output logic dfi_cke,
    output logic dfi_init_start,
    output logic busy,
    output logic ready,
    output logic error
);

    localparam int unsigned CntW = 24;
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] RstLast = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0] CkeLast = CntW'(CKE_CYCLES - 1);

    if (RESET_CYCLES < 1 || RESET_CYCLES > 32'h00FF_FFFF) begin : g_bad_reset_cycles
        $error("RESET_CYCLES out of range");
    end
    if (CKE_CYCLES < 1 || CKE_CYCLES > 32'h00FF_FFFF) begin : g_bad_cke_cycles
        $error("CKE_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_bad_timeout_cycles
        $error("TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {
        StIdle,
        StRstHold,
        StCkeWait,
        StInitReq,
`ifdef DFI_INIT_TIMEOUT_EN
        StDone,
        StFail
`else
        StDone
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic dfi_reset_n_q, dfi_reset_n_d;
    logic dfi_cke_q, dfi_cke_d;
    logic dfi_init_start_q, dfi_init_start_d;
    logic busy_q, busy_d;
    logic ready_q, ready_d;
`ifdef DFI_INIT_TIMEOUT_EN
    localparam logic [CntW-1:0] ToLast = CntW'(TIMEOUT_CYCLES - 1);
    logic error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRstHold;
            end
            StRstHold: begin
                if (cnt_q == RstLast) state_d = StCkeWait;
            end
            StCkeWait: begin
                if (cnt_q == CkeLast) state_d = StInitReq;
            end
            StInitReq: begin
                if (dfi_init_complete) begin
                    state_d = StDone;
`ifdef DFI_INIT_TIMEOUT_EN
                end else if (cnt_q == ToLast) begin
                    state_d = StFail;
`endif
                end
            end
            StDone: begin
                // A restart request wins over a simultaneous loss of training
                if (start) begin
                    state_d = StRstHold;
                end else if (!dfi_init_complete) begin
                    state_d = StInitReq;
                end
            end
`ifdef DFI_INIT_TIMEOUT_EN
            StFail: begin
                if (start) state_d = StRstHold;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered value lines up with the state
    always_comb begin
        dfi_reset_n_d    = 1'b0;
        dfi_cke_d        = 1'b0;
        dfi_init_start_d = 1'b0;
        busy_d           = 1'b0;
        ready_d          = 1'b0;
`ifdef DFI_INIT_TIMEOUT_EN
        error_d          = 1'b0;
`endif
        case (state_d)
            StRstHold: begin
                busy_d = 1'b1;
            end
            StCkeWait: begin
                dfi_reset_n_d = 1'b1;
                busy_d        = 1'b1;
            end
            StInitReq: begin
                dfi_reset_n_d    = 1'b1;
                dfi_cke_d        = 1'b1;
                dfi_init_start_d = 1'b1;
                busy_d           = 1'b1;
            end
            StDone: begin
                dfi_reset_n_d = 1'b1;
                dfi_cke_d     = 1'b1;
                ready_d       = 1'b1;
            end
`ifdef DFI_INIT_TIMEOUT_EN
            StFail: begin
                dfi_reset_n_d = 1'b1;
                dfi_cke_d     = 1'b1;
                error_d       = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            dfi_reset_n_q    <= 1'b0;
            dfi_cke_q        <= 1'b0;
            dfi_init_start_q <= 1'b0;
            busy_q           <= 1'b0;
            ready_q          <= 1'b0;
`ifdef DFI_INIT_TIMEOUT_EN
            error_q          <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            dfi_reset_n_q    <= dfi_reset_n_d;
            dfi_cke_q        <= dfi_cke_d;
            dfi_init_start_q <= dfi_init_start_d;
            busy_q           <= busy_d;
            ready_q          <= ready_d;
`ifdef DFI_INIT_TIMEOUT_EN
            error_q          <= error_d;
`endif
        end
    end

    assign dfi_reset_n    = dfi_reset_n_q;
    assign dfi_cke        = dfi_cke_q;
    assign dfi_init_start = dfi_init_start_q;
    assign busy           = busy_q;
    assign ready          = ready_q;
`ifdef DFI_INIT_TIMEOUT_EN
    assign error          = error_q;
`else
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_dfi_init_ctrl.sv
// Bench for dfi_init_ctrl: directed timing scenarios plus random start/complete/reset traffic
// checked against a timeline model of the init sequence.
module tb_dfi_init_ctrl;

    localparam int RC = 4;
    localparam int CC = 3;
    localparam int TC = 10;

    logic clk_sys = 1'b0;
    logic rst_sys_n;
    logic start;
    logic dfi_init_complete;
    logic dfi_reset_n, dfi_cke, dfi_init_start, busy, ready, error;
    logic [5:0] dut_out;

    always #5 clk_sys = ~clk_sys;

    dfi_init_ctrl #(
        .RESET_CYCLES  (RC),
        .CKE_CYCLES    (CC),
        .TIMEOUT_CYCLES(TC)
    ) u_dut (
        .clk_sys          (clk_sys),
        .rst_sys_n        (rst_sys_n),
        .start            (start),
        .dfi_init_complete(dfi_init_complete),
        .dfi_reset_n      (dfi_reset_n),
        .dfi_cke          (dfi_cke),
        .dfi_init_start   (dfi_init_start),
        .busy             (busy),
        .ready            (ready),
        .error            (error)
    );

    assign dut_out = {busy, ready, error, dfi_init_start, dfi_cke, dfi_reset_n};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Timeline model: a running sequence is described by the cycle its reset phase began (m_t0)
    // and the cycle its current training request began (m_req_t0).
    bit m_run, m_done, m_fail;
    int m_t0, m_req_t0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // {busy, ready, error, init_start, cke, reset_n}
    function automatic logic [5:0] model_out();
        int e;
        if (m_fail) return 6'b001011;
        if (m_done) return 6'b010011;
        if (!m_run) return 6'b000000;
        e = cyc - m_t0;
        return {1'b1, 2'b00, e >= RC + CC, e >= RC + CC, e >= RC};
    endfunction

    task automatic model_step(input bit st, input bit cmp);
        int e;
        if (!m_run) begin
            if (st) begin
                m_run = 1; m_done = 0; m_fail = 0;
                m_t0 = cyc + 1;
                m_req_t0 = m_t0 + RC + CC;
            end else if (m_done && !cmp) begin
                m_run = 1; m_done = 0;
                m_t0 = cyc + 1 - (RC + CC);
                m_req_t0 = cyc + 1;
            end
        end else begin
            e = cyc - m_t0;
            if (e >= RC + CC) begin
                if (cmp) begin
                    m_run = 0; m_done = 1;
`ifdef DFI_INIT_TIMEOUT_EN
                end else if (cyc - m_req_t0 + 1 >= TC) begin
                    m_run = 0; m_fail = 1;
`endif
                end
            end
        end
    endtask

    // Called at a falling edge: drive this cycle's inputs, advance one cycle, compare.
    task automatic tick(input bit st, input bit cmp);
        start = st;
        dfi_init_complete = cmp;
        model_step(st, cmp);
        @(negedge clk_sys);
        cyc++;
        start = 1'b0;
        check_eq("outputs", int'(dut_out), int'(model_out()));
    endtask

    task automatic apply_reset();
        rst_sys_n = 1'b0;
        start = 1'b0;
        #1;
        check_eq("async_reset", int'(dut_out), 0);
        m_run = 0; m_done = 0; m_fail = 0;
        @(negedge clk_sys);
        cyc++;
        rst_sys_n = 1'b1;
        check_eq("after_reset", int'(dut_out), int'(model_out()));
    endtask

    // Start at relative cycle 0, complete from cycle 12, optional extra start at ign_at.
    task automatic nominal(input string tag, input int ign_at);
        for (int r = 0; r < 13; r++) begin
            tick(r == 0 || r == ign_at, r >= 12);
            case (r + 1)
                1, 4: begin
                    check_eq({tag, "_rst_lo"}, int'(dfi_reset_n), 0);
                    check_eq({tag, "_cke_lo"}, int'(dfi_cke), 0);
                end
                5: check_eq({tag, "_rst_hi"}, int'(dfi_reset_n), 1);
                7: check_eq({tag, "_cke_c7"}, int'(dfi_cke), 0);
                8: begin
                    check_eq({tag, "_cke_c8"}, int'(dfi_cke), 1);
                    check_eq({tag, "_istart_c8"}, int'(dfi_init_start), 1);
                end
                12: check_eq({tag, "_istart_c12"}, int'(dfi_init_start), 1);
                13: begin
                    check_eq({tag, "_ready_c13"}, int'(ready), 1);
                    check_eq({tag, "_istart_c13"}, int'(dfi_init_start), 0);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bias;
        rst_sys_n = 1'b0;
        start = 1'b0;
        dfi_init_complete = 1'b0;
        m_run = 0; m_done = 0; m_fail = 0;
        m_t0 = 0; m_req_t0 = 0;
        @(negedge clk_sys);
        check_eq("reset_state", int'(dut_out), 0);
        rst_sys_n = 1'b1;
        repeat (3) tick(1'b0, 1'b1);

        nominal("nom", -1);
        nominal("ign", 6);

        // Retrain from DONE
        tick(1'b0, 1'b0);
        check_eq("retrain_ready", int'(ready), 0);
        check_eq("retrain_istart", int'(dfi_init_start), 1);
        tick(1'b0, 1'b1);
        check_eq("retrain_back", int'(ready), 1);

        // Complete already high on entry to the training request
        for (int r = 0; r < 9; r++) begin
            tick(r == 0, 1'b1);
            if (r + 1 == 8) check_eq("early_istart", int'(dfi_init_start), 1);
        end
        check_eq("early_ready", int'(ready), 1);
        check_eq("early_istart_off", int'(dfi_init_start), 0);

`ifdef DFI_INIT_TIMEOUT_EN
        for (int r = 0; r < 18; r++) begin
            tick(r == 0, 1'b0);
            if (r + 1 == 17) check_eq("to_err_c17", int'(error), 0);
        end
        check_eq("to_err_c18", int'(error), 1);
        check_eq("to_istart_c18", int'(dfi_init_start), 0);
        check_eq("to_cke_c18", int'(dfi_cke), 1);
        tick(1'b1, 1'b0);
        check_eq("to_restart_err", int'(error), 0);
        check_eq("to_restart_rst", int'(dfi_reset_n), 0);
        repeat (8) tick(1'b0, 1'b1);
`else
        tick(1'b1, 1'b0);
        repeat (1000) tick(1'b0, 1'b0);
        check_eq("noto_err", int'(error), 0);
        check_eq("noto_istart", int'(dfi_init_start), 1);
        tick(1'b0, 1'b1);
`endif

        // Reset during the training request
        for (int r = 0; r < 10; r++) tick(r == 0, 1'b0);
        apply_reset();
        for (int r = 0; r < 20; r++) tick(1'b0, 1'($urandom_range(0, 1)));
        check_eq("quiet_after_reset", int'(dut_out), 0);

        // Random traffic
        bias = 80;
        for (int r = 0; r < 4000; r++) begin
            if (r % 100 == 0) bias = $urandom_range(0, 100);
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                tick($urandom_range(0, 15) == 0, $urandom_range(0, 99) < bias);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
